// File: rtl/inv_mixed_column_block.sv
// AES column-mixing engine: InvMixColumns or forward MixColumns on one 4x4 state,
// COLS_PER_CYCLE columns per clock, with valid/ready handshakes on both sides.
module inv_mixed_column_block #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  inv_mode,
    input  logic [3:0][3:0][7:0]  input2mixedcolumn,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [3:0][3:0][7:0]  outputmixedcolumn,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] LAST_COL = 2'(4 - COLS_PER_CYCLE);

    state_t               state, state_next;
    logic [1:0]           col_cnt;
    logic [3:0][3:0][7:0] blk_reg;
    logic [3:0][3:0][7:0] blk_next;
    logic                 mode_reg;
    logic [1:0]           col_off;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Every coefficient used fits in four bits, so the product is a masked sum of b, 2b, 4b, 8b.
    function automatic logic [7:0] gf_mul(input logic [7:0] b, input logic [3:0] coef);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return ({8{coef[3]}} & x8) ^ ({8{coef[2]}} & x4) ^
               ({8{coef[1]}} & x2) ^ ({8{coef[0]}} & b);
    endfunction

    function automatic logic [3:0][7:0] mix_col(input logic [3:0][7:0] col, input logic inv);
        logic [3:0][3:0] coef;
        logic [3:0][7:0] res;
        coef = inv ? {4'h9, 4'hd, 4'hb, 4'he} : {4'h1, 4'h1, 4'h3, 4'h2};
        res  = '0;
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 4; k++) begin
                res[r] = res[r] ^ gf_mul(col[k], coef[2'(k - r)]);
            end
        end
        return res;
    endfunction

    // Column c is in this cycle's window when its offset from col_cnt is below COLS_PER_CYCLE.
    always_comb begin
        blk_next = blk_reg;
        col_off  = '0;
        for (int c = 0; c < 4; c++) begin
            col_off = 2'(c) - col_cnt;
            if (int'(col_off) < COLS_PER_CYCLE) begin
                blk_next[c] = mix_col(blk_reg[c], mode_reg);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)            state_next = BUSY;
            BUSY:    if (col_cnt == LAST_COL) state_next = DONE;
            DONE:    if (out_ready)           state_next = IDLE;
            default:                          state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_cnt           <= '0;
            blk_reg           <= '0;
            mode_reg          <= 1'b1;
            outputmixedcolumn <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        blk_reg  <= input2mixedcolumn;
                        mode_reg <= inv_mode;
                        col_cnt  <= '0;
                    end
                end
                BUSY: begin
                    blk_reg <= blk_next;
                    col_cnt <= col_cnt + COL_STEP;
                    if (col_cnt == LAST_COL) outputmixedcolumn <= blk_next;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE) && rst_n;
    assign out_valid = (state == DONE);
    assign busy      = (state == BUSY);

endmodule

// File: tb/tb_inv_mixed_column_block.sv
// Scoreboard bench for inv_mixed_column_block: one instance per legal COLS_PER_CYCLE,
// expected states from constants or an independent GF(2^8) reference model.
module tb_inv_mixed_column_block;

    typedef logic [3:0][3:0][7:0] blk_t;
    typedef logic [3:0][7:0]      col_t;

    logic clk = 1'b0;
    logic rst_n;
    logic inv_mode;
    blk_t din;
    logic in_valid1, in_valid2, in_valid4;
    logic out_ready1;
    logic out_ready_w = 1'b1;
    logic ir1, ir2, ir4, ov1, ov2, ov4, busy1, busy2, busy4;
    blk_t do1, do2, do4;

    int checks   = 0;
    int failures = 0;
    blk_t exp_q[$];

    always #5 clk = ~clk;

    inv_mixed_column_block #(.COLS_PER_CYCLE(1)) u_c1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(ir1), .inv_mode(inv_mode),
        .input2mixedcolumn(din), .out_valid(ov1), .out_ready(out_ready1),
        .outputmixedcolumn(do1), .busy(busy1));

    inv_mixed_column_block #(.COLS_PER_CYCLE(2)) u_c2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(ir2), .inv_mode(inv_mode),
        .input2mixedcolumn(din), .out_valid(ov2), .out_ready(out_ready_w),
        .outputmixedcolumn(do2), .busy(busy2));

    inv_mixed_column_block #(.COLS_PER_CYCLE(4)) u_c4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(ir4), .inv_mode(inv_mode),
        .input2mixedcolumn(din), .out_valid(ov4), .out_ready(out_ready_w),
        .outputmixedcolumn(do4), .busy(busy4));

    function automatic col_t col(input logic [7:0] b0, b1, b2, b3);
        return {b3, b2, b1, b0};
    endfunction

    function automatic blk_t st(input col_t c0, c1, c2, c3);
        return {c3, c2, c1, c0};
    endfunction

    // Shift-and-add GF(2^8) multiply, reduced by 0x11B.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        logic       hi;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            hi = aa[7];
            aa = {aa[6:0], 1'b0};
            if (hi) aa = aa ^ 8'h1b;
            bb = {1'b0, bb[7:1]};
        end
        return p;
    endfunction

    function automatic blk_t ref_mix(input blk_t s, input logic inv);
        logic [7:0] cf [4];
        blk_t       o;
        if (inv) begin cf[0] = 8'h0e; cf[1] = 8'h0b; cf[2] = 8'h0d; cf[3] = 8'h09; end
        else     begin cf[0] = 8'h02; cf[1] = 8'h03; cf[2] = 8'h01; cf[3] = 8'h01; end
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                for (int k = 0; k < 4; k++)
                    o[c][r] = o[c][r] ^ gmul(cf[(k - r + 4) % 4], s[c][k]);
        return o;
    endfunction

    function automatic blk_t rand_blk();
        blk_t b;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                b[c][r] = 8'($urandom);
        return b;
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Called at a negedge; leaves the bench at the negedge right after the accepting edge.
    task automatic applyStimulus(input blk_t data, input logic mode, input blk_t expected);
        checkOutput("accept_ready", 128'(ir1), 128'(1));
        din       = data;
        inv_mode  = mode;
        in_valid1 = 1'b1;
        exp_q.push_back(expected);
        @(negedge clk);
        in_valid1 = 1'b0;
        inv_mode  = ~mode;
        din       = rand_blk();
    endtask

    task automatic collectResult(input string tag, input int lat_exp, input int hold, output blk_t got);
        int   lat;
        blk_t e;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            if (ov1) break;
            @(negedge clk);
            if (ov1) lat = i;
        end
        checkOutput({tag, "_lat"}, 128'(lat), 128'(lat_exp));
        e = 'x;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        got = do1;
        checkOutput({tag, "_data"}, do1, e);
        for (int i = 0; i < hold; i++) begin
            in_valid1 = ~in_valid1;
            inv_mode  = ~inv_mode;
            din       = rand_blk();
            @(negedge clk);
            checkOutput({tag, "_hold_data"}, do1, e);
            checkOutput({tag, "_hold_valid"}, 128'(ov1), 128'(1));
            checkOutput({tag, "_hold_ready"}, 128'(ir1), 128'(0));
        end
        in_valid1  = 1'b0;
        out_ready1 = 1'b1;
        @(negedge clk);
        out_ready1 = 1'b0;
        checkOutput({tag, "_idle"}, 128'({ov1, ir1}), 128'(2'b01));
    endtask

    task automatic runWide(input string tag, input blk_t data, input logic mode, input blk_t expected);
        int   l2, l4;
        blk_t d2, d4;
        l2 = -1;
        l4 = -1;
        d2 = 'x;
        d4 = 'x;
        din       = data;
        inv_mode  = mode;
        in_valid2 = 1'b1;
        in_valid4 = 1'b1;
        @(negedge clk);
        in_valid2 = 1'b0;
        in_valid4 = 1'b0;
        inv_mode  = ~mode;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (ov2 && l2 < 0) begin l2 = i; d2 = do2; end
            if (ov4 && l4 < 0) begin l4 = i; d4 = do4; end
        end
        checkOutput({tag, "_c2_lat"}, 128'(l2), 128'(2));
        checkOutput({tag, "_c2_data"}, d2, expected);
        checkOutput({tag, "_c4_lat"}, 128'(l4), 128'(1));
        checkOutput({tag, "_c4_data"}, d4, expected);
    endtask

    initial begin
        blk_t c01, s_in, s_out, one_in, one_out, fp, r1, r2, ra, got;
        int   cyc, t_out_a, t_acc_b, nout;
        blk_t e;

        c01     = col(8'h01, 8'h01, 8'h01, 8'h01);
        one_in  = st(col(8'h8e, 8'h4d, 8'ha1, 8'hbc), c01, c01, c01);
        one_out = st(col(8'hdb, 8'h13, 8'h53, 8'h45), c01, c01, c01);
        s_in    = st(col(8'h8e, 8'h4d, 8'ha1, 8'hbc), col(8'h9f, 8'hdc, 8'h58, 8'h9d),
                     col(8'hd5, 8'hd5, 8'hd7, 8'hd6), col(8'h4d, 8'h7e, 8'hbd, 8'hf8));
        s_out   = st(col(8'hdb, 8'h13, 8'h53, 8'h45), col(8'hf2, 8'h0a, 8'h22, 8'h5c),
                     col(8'hd4, 8'hd4, 8'hd4, 8'hd5), col(8'h2d, 8'h26, 8'h31, 8'h4c));
        fp      = st(col(8'hc6, 8'hc6, 8'hc6, 8'hc6), c01, col(8'hc6, 8'hc6, 8'hc6, 8'hc6), c01);

        rst_n      = 1'b0;
        in_valid1  = 1'b0;
        in_valid2  = 1'b0;
        in_valid4  = 1'b0;
        out_ready1 = 1'b0;
        inv_mode   = 1'b0;
        din        = '0;
        repeat (2) @(negedge clk);
        checkOutput("rst_in_ready", 128'(ir1), 128'(0));
        checkOutput("rst_out_valid", 128'(ov1), 128'(0));
        checkOutput("rst_busy", 128'(busy1), 128'(0));
        checkOutput("rst_data", do1, '0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("idle_in_ready", 128'(ir1), 128'(1));

        $display("[TB] inverse single column");
        applyStimulus(one_in, 1'b1, one_out);
        collectResult("inv_col0", 4, 0, got);

        $display("[TB] inverse full state, all widths");
        applyStimulus(s_in, 1'b1, s_out);
        collectResult("inv_full", 4, 0, got);
        runWide("inv_full", s_in, 1'b1, s_out);

        $display("[TB] forward mode and round trip");
        applyStimulus(s_out, 1'b0, s_in);
        collectResult("fwd_full", 4, 0, got);
        applyStimulus(got, 1'b1, s_out);
        collectResult("round_trip", 4, 0, got);
        runWide("fwd_full", s_out, 1'b0, s_in);

        $display("[TB] fixed points");
        applyStimulus(fp, 1'b0, fp);
        collectResult("fp_fwd", 4, 0, got);
        applyStimulus(fp, 1'b1, fp);
        collectResult("fp_inv", 4, 0, got);

        $display("[TB] random states against reference model");
        r1 = rand_blk();
        applyStimulus(r1, 1'b0, ref_mix(r1, 1'b0));
        collectResult("rnd_fwd", 4, 0, got);
        applyStimulus(got, 1'b1, r1);
        collectResult("rnd_round_trip", 4, 0, got);
        r2 = rand_blk();
        applyStimulus(r2, 1'b1, ref_mix(r2, 1'b1));
        collectResult("rnd_inv", 4, 0, got);
        runWide("rnd_inv", r2, 1'b1, ref_mix(r2, 1'b1));

        $display("[TB] backpressure");
        applyStimulus(s_in, 1'b1, s_out);
        collectResult("bp", 4, 10, got);

        $display("[TB] reset mid-operation");
        din       = s_in;
        inv_mode  = 1'b1;
        in_valid1 = 1'b1;
        @(negedge clk);
        in_valid1 = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("mid_busy", 128'(busy1), 128'(1));
        #2 rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_out_valid", 128'(ov1), 128'(0));
        checkOutput("mid_rst_busy", 128'(busy1), 128'(0));
        checkOutput("mid_rst_data", do1, '0);
        checkOutput("mid_rst_in_ready", 128'(ir1), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(one_in, 1'b1, one_out);
        collectResult("post_rst", 4, 0, got);

        $display("[TB] back-to-back");
        ra = rand_blk();
        exp_q.push_back(ref_mix(ra, 1'b1));
        exp_q.push_back(s_out);
        din        = ra;
        inv_mode   = 1'b1;
        in_valid1  = 1'b1;
        out_ready1 = 1'b1;
        @(negedge clk);
        din     = s_in;
        cyc     = 0;
        t_out_a = -1;
        t_acc_b = -1;
        nout    = 0;
        for (int i = 0; i < 30 && nout < 2; i++) begin
            @(negedge clk);
            cyc++;
            if (t_acc_b >= 0) in_valid1 = 1'b0;
            if (ov1) begin
                e = 'x;
                if (exp_q.size() > 0) e = exp_q.pop_front();
                checkOutput("b2b_data", do1, e);
                nout++;
                if (nout == 1) t_out_a = cyc;
            end
            if (in_valid1 && ir1 && t_acc_b < 0) t_acc_b = cyc;
        end
        in_valid1  = 1'b0;
        out_ready1 = 1'b0;
        checkOutput("b2b_count", 128'(nout), 128'(2));
        checkOutput("b2b_first_lat", 128'(t_out_a), 128'(4));
        checkOutput("b2b_second_accept", 128'(t_acc_b), 128'(t_out_a + 1));
        checkOutput("scoreboard_empty", 128'(exp_q.size()), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
